// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg -- shared definitions for the cpu_sequencer slice.
//
// Contents:
//   state_t   : sequencer state encoding. S_ERR exists only when
//               CPU_SEQ_ILLEGAL_TRAP_EN is defined.
//   iclass_t  : instruction class produced by cpu_seq_decode.
//   OPC_* / OP_* : instruction field constants (opcode = bits [15:13],
//               op = bits [12:11]).
//   VSEL_*    : write-back source select codes.
//   NSEL_*    : one-hot register-file select codes.
//
// Configuration macro: CPU_SEQ_ILLEGAL_TRAP_EN
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_MOVIMM = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_ALU    = 3'd5,
        S_WRITE  = 3'd6
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        ,
        S_ERR    = 3'd7
`endif
    } state_t;

    typedef enum logic [2:0] {
        IC_MOVIMM  = 3'd0,
        IC_MOVREG  = 3'd1,
        IC_ALU_WB  = 3'd2,
        IC_CMP     = 3'd3,
        IC_ILLEGAL = 3'd4
    } iclass_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b01;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RN    = 3'b100;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RM    = 3'b001;

endpackage

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode -- combinational instruction classifier.
//
// Ports:
//   opcode_i [2:0] : instruction bits [15:13]
//   op_i     [1:0] : instruction bits [12:11]
//   iclass_o [2:0] : iclass_t value (MOVIMM, MOVREG, ALU_WB, CMP, ILLEGAL)
//
// Configuration macro: CPU_SEQ_ILLEGAL_TRAP_EN (not used here; the
// classification is identical in both builds).
module cpu_seq_decode
    import cpu_seq_pkg::*;
(
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    output logic [2:0] iclass_o
);

    iclass_t iclass;

    always_comb begin
        iclass = IC_ILLEGAL;
        if (opcode_i == OPC_MOV) begin
            if (op_i == OP_MOV_IMM) begin
                iclass = IC_MOVIMM;
            end else if (op_i == OP_MOV_REG) begin
                iclass = IC_MOVREG;
            end
        end else if (opcode_i == OPC_ALU) begin
            // ADD, AND and MVN all write back through C; only CMP stops at flags.
            iclass = (op_i == OP_CMP) ? IC_CMP : IC_ALU_WB;
        end
    end

    assign iclass_o = iclass;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- Moore control FSM for a simple register/ALU datapath.
//
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset, forces S_WAIT
//   s              : start, sampled only in S_WAIT
//   opcode [2:0]   : instruction bits [15:13], stable for the instruction
//   op     [1:0]   : instruction bits [12:11], stable for the instruction
//   nsel   [2:0]   : one-hot register select (100=Rn, 010=Rd, 001=Rm)
//   vsel   [1:0]   : write-back source (00=C, 01=sign-extended imm8)
//   loada, loadb, loadc, loads, write, asel, bsel : datapath strobes/selects
//   w              : high only in S_WAIT
//   err            : illegal-instruction flag (sticky until reset when trapping)
//   dbg_state [2:0]: current FSM state (state_t encoding)
//
// Configuration macro: CPU_SEQ_ILLEGAL_TRAP_EN
//   defined   : illegal decode goes to S_ERR, err=1 until reset
//   undefined : illegal decode returns to S_WAIT, err tied low
module cpu_sequencer
    import cpu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic       w,
    output logic       err,
    output logic [2:0] dbg_state
);

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_ERR;
`else
    localparam state_t ILLEGAL_NEXT = S_WAIT;
`endif

    state_t     state_q, state_d;
    // Cleared by reset and set by the first clock edge afterwards, so the
    // edge that ends reset never accepts a start.
    logic       armed_q;
    logic [2:0] iclass_w;
    iclass_t    iclass;

    cpu_seq_decode u_decode (
        .opcode_i (opcode),
        .op_i     (op),
        .iclass_o (iclass_w)
    );

    assign iclass = iclass_t'(iclass_w);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s && armed_q) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (iclass)
                    IC_MOVIMM: state_d = S_MOVIMM;
                    IC_MOVREG: state_d = S_GETB;   // MOV Rd,Rm skips the A read
                    IC_ALU_WB: state_d = S_GETA;
                    IC_CMP:    state_d = S_GETA;
                    default:   state_d = ILLEGAL_NEXT;
                endcase
            end
            S_MOVIMM: state_d = S_WAIT;
            S_GETA:   state_d = S_GETB;
            S_GETB:   state_d = S_ALU;
            S_ALU:    state_d = (iclass == IC_CMP) ? S_WAIT : S_WRITE;
            S_WRITE:  state_d = S_WAIT;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            S_ERR:    state_d = S_ERR;
`endif
            default:  state_d = S_WAIT;
        endcase
    end

    // Moore outputs: state plus the (stable) instruction fields only
    always_comb begin
        nsel  = NSEL_NONE;
        vsel  = VSEL_C;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        write = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        case (state_q)
            S_MOVIMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            S_GETA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GETB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                // MOV Rd,Rm never loaded A, so force the A operand to zero.
                asel  = (iclass == IC_MOVREG);
                loads = (iclass == IC_CMP);
                loadc = (iclass != IC_CMP);
            end
            S_WRITE: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w         = (state_q == S_WAIT);
    assign dbg_state = state_q;

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    assign err = (state_q == S_ERR);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer -- self-checking bench for cpu_sequencer.
//
// A behavioural model turns each accepted start into a per-cycle script of
// expected output vectors built from the instruction's documented step list.
// A compare process checks every cycle against it; directed runs pin the
// documented latencies with literal cycle numbers; a random phase follows.
//
// Configuration macro: CPU_SEQ_ILLEGAL_TRAP_EN (bench follows the build).
`timescale 1ns/1ps
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, write, asel, bsel, w, err;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .opcode    (opcode),
        .op        (op),
        .nsel      (nsel),
        .vsel      (vsel),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .write     (write),
        .asel      (asel),
        .bsel      (bsel),
        .w         (w),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Output vector: {w, err, nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, write, asel, bsel}
    localparam logic [13:0] IDLE_V = 14'h2000;
    localparam logic [13:0] ERR_V  = 14'h1000;
    localparam logic [13:0] ZERO_V = 14'h0000;

    // strobes order: loada loadb loadc loads write asel bsel
    function automatic logic [13:0] vec(input logic [2:0] ns, input logic [1:0] vs, input logic [6:0] st);
        return {1'b0, 1'b0, ns, vs, st};
    endfunction

    // ---------------- behavioural model ----------------
    logic [13:0] exp_q[$];
    bit          trap_pending = 1'b0;
    bit          trapped      = 1'b0;
    bit          hold_s       = 1'b1;

    task automatic push_script(input logic [2:0] opc, input logic [1:0] o);
        exp_q.push_back(ZERO_V);                                     // decode
        if (opc == 3'b110 && o == 2'b10) begin                       // MOV Rn,#imm
            exp_q.push_back(vec(3'b100, 2'b01, 7'b0000100));
        end else if (opc == 3'b110 && o == 2'b00) begin              // MOV Rd,Rm
            exp_q.push_back(vec(3'b001, 2'b00, 7'b0100000));
            exp_q.push_back(vec(3'b000, 2'b00, 7'b0010010));
            exp_q.push_back(vec(3'b010, 2'b00, 7'b0000100));
        end else if (opc == 3'b101) begin                            // ALU ops
            exp_q.push_back(vec(3'b100, 2'b00, 7'b1000000));
            exp_q.push_back(vec(3'b001, 2'b00, 7'b0100000));
            if (o == 2'b01) begin
                exp_q.push_back(vec(3'b000, 2'b00, 7'b0001000));
            end else begin
                exp_q.push_back(vec(3'b000, 2'b00, 7'b0010000));
                exp_q.push_back(vec(3'b010, 2'b00, 7'b0000100));
            end
        end else begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            trap_pending = 1'b1;
`endif
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            trap_pending = 1'b0;
            trapped      = 1'b0;
            hold_s       = 1'b1;
        end else begin
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0 && trap_pending) begin
                    trapped      = 1'b1;
                    trap_pending = 1'b0;
                end
            end else if (!trapped && !hold_s && s) begin
                push_script(opcode, op);
            end
            hold_s = 1'b0;
        end
    end

    function automatic logic [13:0] model_now();
        if (exp_q.size() != 0) return exp_q[0];
        if (trapped) return ERR_V;
        return IDLE_V;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #3;
        chk("cycle_outputs",
            {18'd0, w, err, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel},
            {18'd0, model_now()});
    end

    // ---------------- driver tasks ----------------
    int t_la, t_lb, t_lc, t_ls, t_wr, t_wr2, t_w, t_err, n_wr, n_lc;

    task automatic idle(input int n);
        s = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Start one instruction and record, per signal, the first cycle (counted
    // from the s-sample edge) at which it is seen high.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int ncyc, input bit hold);
        t_la = -1; t_lb = -1; t_lc = -1; t_ls = -1; t_wr = -1; t_wr2 = -1;
        t_w = -1; t_err = -1; n_wr = 0; n_lc = 0;
        @(negedge clk);
        opcode = opc; op = o; s = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) @(posedge clk);
            #3;
            if (loada && t_la < 0) t_la = k;
            if (loadb && t_lb < 0) t_lb = k;
            if (loadc && t_lc < 0) t_lc = k;
            if (loads && t_ls < 0) t_ls = k;
            if (w     && t_w  < 0) t_w  = k;
            if (err   && t_err < 0) t_err = k;
            if (write) begin
                if (t_wr < 0) t_wr = k;
                else if (t_wr2 < 0) t_wr2 = k;
                n_wr++;
            end
            if (loadc) n_lc++;
            if (k == 1 && !hold) begin
                @(negedge clk);
                s = 1'b0;
            end
        end
        @(negedge clk);
        s = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        @(posedge clk); @(posedge clk); #3;
        chk("reset_outputs",
            {18'd0, w, err, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel},
            {18'd0, IDLE_V});
        chk("reset_state", {29'd0, dbg_state}, {29'd0, S_WAIT});
        @(negedge clk); reset = 1'b0;
        idle(2);

        // MOV R0,#32
        run_instr(3'b110, 2'b10, 4, 1'b0);
        chk("movimm_write_cycle", t_wr, 2);
        chk("movimm_w_cycle",     t_w,  3);
        chk("movimm_write_count", n_wr, 1);
        idle(2);

        // ADD
        run_instr(3'b101, 2'b00, 7, 1'b0);
        chk("add_loada_cycle", t_la, 2);
        chk("add_loadb_cycle", t_lb, 3);
        chk("add_loadc_cycle", t_lc, 4);
        chk("add_write_cycle", t_wr, 5);
        chk("add_w_cycle",     t_w,  6);
        idle(2);

        // CMP
        run_instr(3'b101, 2'b01, 6, 1'b0);
        chk("cmp_loads_cycle", t_ls, 4);
        chk("cmp_w_cycle",     t_w,  5);
        chk("cmp_write_count", n_wr, 0);
        chk("cmp_loadc_count", n_lc, 0);
        idle(2);

        // MOV Rd,Rm
        run_instr(3'b110, 2'b00, 6, 1'b0);
        chk("movreg_write_cycle", t_wr, 4);
        chk("movreg_w_cycle",     t_w,  5);
        idle(2);

        // Back-to-back MOV imm with s held high
        run_instr(3'b110, 2'b10, 6, 1'b1);
        chk("b2b_first_write",  t_wr,  2);
        chk("b2b_write_gap",    t_wr2 - t_wr, 3);
        idle(6);

        // Reset during S_GETB of an ADD
        @(negedge clk); opcode = 3'b101; op = 2'b00; s = 1'b1;
        @(posedge clk); #3;
        @(negedge clk); s = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        chk("rst_getb_loadb", {31'd0, loadb}, 32'd1);
        @(negedge clk); reset = 1'b1; #1;
        chk("rst_getb_w_same_cycle", {31'd0, w}, 32'd1);
        chk("rst_getb_write_low", {31'd0, write}, 32'd0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        n_wr = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #3;
            if (write || loadc) n_wr++;
        end
        chk("rst_getb_no_writeback", n_wr, 0);

        // s high across reset release is ignored on the first edge
        @(negedge clk); reset = 1'b1; opcode = 3'b110; op = 2'b10; s = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #3;
        chk("post_reset_s_ignored", {31'd0, w}, 32'd1);
        @(posedge clk); #3;
        chk("post_reset_s_taken", {31'd0, w}, 32'd0);
        @(negedge clk); s = 1'b0;
        idle(4);

        // Illegal instruction {111,00}
        run_instr(3'b111, 2'b00, 6, 1'b0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        chk("illegal_err_cycle", t_err, 2);
        chk("illegal_w_never",   t_w,  -1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
`else
        chk("illegal_w_cycle",   t_w,   2);
        chk("illegal_err_never", t_err, -1);
`endif
        idle(3);

        // Randomized phase
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (reset) begin
                if ($urandom_range(0, 1) == 1) reset = 1'b0;
            end else if (trapped || $urandom_range(0, 79) == 0) begin
                reset = 1'b1;
                s = $urandom_range(0, 1);
            end else if (exp_q.size() == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    opcode = 3'b110; op = 2'b10;
                end else if (r < 3) begin
                    opcode = 3'b110; op = 2'b00;
                end else if (r < 7) begin
                    opcode = 3'b101; op = 2'($urandom_range(0, 3));
                end else begin
                    opcode = 3'($urandom_range(0, 7)); op = 2'($urandom_range(0, 3));
                end
                s = ($urandom_range(0, 2) != 0);
            end else begin
                s = $urandom_range(0, 1);   // must be ignored mid-instruction
            end
        end
        @(negedge clk); reset = 1'b0; s = 1'b0;
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
